// File: rtl/mem_stream_reader.sv
// mem_stream_reader: reads NM parallel memories one shared address at a time.
// For each address it streams the captured NM*B-bit word as NM/L AXI-Stream beats.
// The transfer starts at ADDR_REG and covers LEN_REG addresses (0 means 2**N).
// The address wraps modulo 2**N.
// Optional feature: define MEM_STREAM_READER_TUSER_EN to add m_axis_tuser.
// m_axis_tuser carries {address, beat index} alongside m_axis_tdata.
module mem_stream_reader #(
    parameter  int NM     = 8,   // memories read in parallel, power of 2
    parameter  int N      = 8,   // address width, depth 2**N
    parameter  int B      = 8,   // data width per memory
    parameter  int L      = 1,   // memory words per beat, power of 2, 1..NM
    parameter  int RD_LAT = 1,   // memory read latency, 1..4
    localparam int NB     = NM / L,
    localparam int BW     = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic            aclk,
    input  logic            aresetn,
    output logic [N-1:0]    mem_addr,
    input  logic [NM*B-1:0] mem_dout,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [L*B-1:0]  m_axis_tdata,
    output logic            m_axis_tlast,
`ifdef MEM_STREAM_READER_TUSER_EN
    output logic [N+BW-1:0] m_axis_tuser,
`endif
    input  logic            START_REG,
    input  logic [N-1:0]    ADDR_REG,
    input  logic [N-1:0]    LEN_REG,
    output logic            BUSY_REG
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_END
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic            r_start_meta;
    logic            r_start_sync;

    logic [N-1:0]    r_addr;      // current address, also drives mem_addr
    logic [N:0]      r_left;      // addresses remaining, including the current one
    logic [2:0]      r_lat_cnt;   // cycles spent in WAIT
    logic [NM*B-1:0] r_capture;   // word captured from all memories
    logic [BW-1:0]   r_beat;      // beat index within the captured word

    logic            w_handshake;
    logic            w_last_beat;
    logic            w_last_word;
    logic            w_wait_done;
    logic [L*B-1:0]  w_beat_data;

    assign w_handshake = (r_state == S_WRITE) && m_axis_tready;
    assign w_last_beat = (r_beat == BW'(NB - 1));
    assign w_last_word = (r_left == (N+1)'(1));
    assign w_wait_done = (r_lat_cnt == 3'(RD_LAT - 1));
    assign w_beat_data = r_capture[int'(r_beat) * (L*B) +: L*B];

    // mem_addr holds between READ phases because r_addr only moves when entering READ.
    assign mem_addr = r_addr;

    // Two-flop resynchroniser for the asynchronous level-sensitive start.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_start_meta <= 1'b0;
            r_start_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking so both flops sample their inputs from before the edge.
            r_start_meta <= START_REG;
            r_start_sync <= r_start_meta;
        end
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (r_start_sync) w_next_state = S_READ;
            S_READ:  w_next_state = S_WAIT;
            S_WAIT:  if (w_wait_done) w_next_state = S_WRITE;
            S_WRITE: begin
                if (w_handshake && w_last_beat) begin
                    w_next_state = w_last_word ? S_END : S_READ;
                end
            end
            S_END:   if (!r_start_sync) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: latch parameters, count wait cycles, capture data, step beats/addresses.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_addr    <= '0;
            r_left    <= '0;
            r_lat_cnt <= '0;
            // NOTE: the capture register is reset too, so no stale word can reach tdata after reset.
            r_capture <= '0;
            r_beat    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_start_sync) begin
                        r_addr <= ADDR_REG;
                        r_left <= (LEN_REG == '0) ? {1'b1, {N{1'b0}}} : {1'b0, LEN_REG};
                        r_beat <= '0;
                    end
                end
                S_READ: begin
                    r_lat_cnt <= '0;
                end
                S_WAIT: begin
                    r_lat_cnt <= r_lat_cnt + 3'd1;
                    if (w_wait_done) begin
                        r_capture <= mem_dout;
                    end
                end
                S_WRITE: begin
                    if (w_handshake) begin
                        if (w_last_beat) begin
                            r_beat <= '0;
                            r_left <= r_left - (N+1)'(1);
                            if (!w_last_word) begin
                                r_addr <= r_addr + N'(1);
                            end
                        end else begin
                            r_beat <= r_beat + BW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from the current state.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        BUSY_REG      = 1'b0;
        case (r_state)
            S_READ, S_WAIT: BUSY_REG = 1'b1;
            S_WRITE: begin
                BUSY_REG      = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = w_beat_data;
                m_axis_tlast  = w_last_beat && w_last_word;
            end
            default: begin
            end
        endcase
    end

`ifdef MEM_STREAM_READER_TUSER_EN
    // Sideband {address, beat index}, held by the same registers as tdata.
    always_comb begin
        m_axis_tuser = '0;
        if (r_state == S_WRITE) begin
            m_axis_tuser = {r_addr, r_beat};
        end
    end
`endif

endmodule
